// File: rtl/event_encoder_8to3.sv
// -----------------------------------------------------------------------------
// event_encoder_8to3
//
// Captures events on eight request lines and issues them one at a time as 3-bit
// binary codes over a valid/ready handshake. Captured events wait in a pending
// bit-vector. A two-state FSM loads one of them into code_out. The FSM can load
// a new code in the same cycle that the consumer takes the current one, so one
// code can be issued per clock.
//
// Parameters
//   EDGE_MODE  1: rising edges of Xin are events; 0: a high level is a request
//
// Build option
//   ENC_RR_EN  defined: round-robin select, starting one past the last issued
//              line. Undefined: fixed priority, lowest index wins.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   Xin       in   [7:0] event/request lines, synchronous to clk
//   code_out  out  [2:0] index of the granted line, meaningful while valid=1
//   valid     out  code_out holds an un-consumed code
//   ready     in   consumer accepts code_out (fire = valid & ready)
//   pending   out  [7:0] captured events not yet issued
//   overflow  out  sticky: an edge arrived on a line that was already pending
//   clr_ovf   in   synchronous clear of overflow (a coincident set wins)
// -----------------------------------------------------------------------------
module event_encoder_8to3 #(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Xin,
    output logic [2:0] code_out,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overflow,
    input  logic       clr_ovf
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e     state_q, state_d;
    logic [7:0] xin_d_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic [2:0] last_idx_q, last_idx_d;
    logic       ovf_q, ovf_d;

    logic [7:0] ev;
    logic [2:0] sel_idx;
    logic       load;
    logic [7:0] load_mask;
    logic       ovf_set;

    assign ev = (EDGE_MODE != 0) ? (Xin & ~xin_d_q) : Xin;

    // The select reads only the registered pending vector. An event arriving
    // in this cycle cannot be granted in this same cycle.
`ifdef ENC_RR_EN
    logic [2:0] cand;

    always_comb begin
        sel_idx = 3'd0;
        cand    = 3'd0;
        // Walk from the farthest candidate (last_idx itself) to the nearest
        // (last_idx+1). The nearest pending line is assigned last, so it wins.
        for (int k = 8; k >= 1; k--) begin
            cand = last_idx_q + 3'(k);
            if (pending_q[cand]) begin
                sel_idx = cand;
            end
        end
    end
`else
    always_comb begin
        sel_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_idx = 3'(k);
            end
        end
    end
`endif

    // FSM next state, code load and last-grant tracking
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        last_idx_d = last_idx_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    load    = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready) begin
                    if (|pending_q) begin
                        // Back-to-back: the next code replaces the fired one.
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            code_d     = sel_idx;
            last_idx_d = sel_idx;
        end
    end

    assign load_mask = load ? (8'd1 << sel_idx) : 8'd0;

    // A new event on the line being loaded keeps that bit set. The event is a
    // separate request from the one being issued.
    assign pending_d = (pending_q & ~load_mask) | ev;

    // In level mode a held request re-asserts every cycle by design, so level
    // mode never reports overflow.
    assign ovf_set = |(ev & pending_q & ~load_mask);
    assign ovf_d   = (EDGE_MODE != 0) && (ovf_set || (ovf_q && !clr_ovf));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            xin_d_q    <= 8'd0;
            pending_q  <= 8'd0;
            code_q     <= 3'd0;
            last_idx_q <= 3'd7;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xin_d_q    <= Xin;
            pending_q  <= pending_d;
            code_q     <= code_d;
            last_idx_q <= last_idx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign code_out = code_q;
    assign valid    = (state_q == StHold);
    assign pending  = pending_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
`timescale 1ns/1ps
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] Xin = 8'd0;
    logic       ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] code_out;
    logic       valid;
    logic [7:0] pending;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    event_encoder_8to3 #(.EDGE_MODE(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Xin      (Xin),
        .code_out (code_out),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    // Downstream 3-to-8 decoder for the round-trip test
    logic [7:0] decoded;
    assign decoded = valid ? (8'd1 << code_out) : 8'd0;

    // Reference model: a set of pending lines plus the currently offered code
    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] xd;
        logic       valid;
        int         code;
        int         last;
        logic       ovf;
    } model_t;

    localparam model_t MRST = '{pend: 8'd0, xd: 8'd0, valid: 1'b0, code: 0, last: 7, ovf: 1'b0};

    model_t m;

    function automatic model_t model_next(model_t cur, logic [7:0] x, logic rdy, logic clr);
        model_t nxt;
        bit     fire;
        bit     load;
        bit     set;
        int     idx;
        int     start;
        bit     evb;
        nxt   = cur;
        fire  = cur.valid && rdy;
        load  = (cur.pend != 8'd0) && (!cur.valid || fire);
        idx   = -1;
        set   = 0;
`ifdef ENC_RR_EN
        start = (cur.last + 1) % 8;
`else
        start = 0;
`endif
        if (load) begin
            for (int k = 0; k < 8; k++) begin
                if (idx < 0 && cur.pend[(start + k) % 8]) idx = (start + k) % 8;
            end
        end
        for (int i = 0; i < 8; i++) begin
            evb         = x[i] && !cur.xd[i];
            nxt.pend[i] = (cur.pend[i] && i != idx) || evb;
            if (evb && cur.pend[i] && i != idx) set = 1;
        end
        nxt.ovf = set || (cur.ovf && !clr);
        nxt.xd  = x;
        if (load) begin
            nxt.valid = 1'b1;
            nxt.code  = idx;
            nxt.last  = idx;
        end else if (fire) begin
            nxt.valid = 1'b0;
        end
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= MRST;
        else        m <= model_next(m, Xin, ready, clr_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (code_out !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code_out); end
        checks++; if (pending !== 8'd0) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", valid); end
    endtask

    task automatic test_single_edge();
        ready = 1'b1;
        Xin = 8'h20;
        tick();
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL single_pend1 got=%h exp=20", pending); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid1 got=%b exp=0", valid); end
        Xin = 8'h00;
        tick();
        checks++; if (valid !== 1'b1 || code_out !== 3'd5) begin
            errors++; $display("FAIL single_code got=v%b/%0d exp=v1/5", valid, code_out); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pend2 got=%h exp=00", pending); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid3 got=%b exp=0", valid); end
    endtask

    task automatic test_burst();
        int exp_code [3];
`ifdef ENC_RR_EN
        exp_code = '{7, 0, 4};
`else
        exp_code = '{0, 4, 7};
`endif
        ready = 1'b1;
        // Issue line 4 first so the round-robin pointer sits at 4
        Xin = 8'h10;
        tick();
        Xin = 8'h00;
        tick();
        checks++; if (valid !== 1'b1 || code_out !== 3'd4) begin
            errors++; $display("FAIL burst_pre got=v%b/%0d exp=v1/4", valid, code_out); end
        tick();
        Xin = 8'h91;
        tick();
        checks++; if (pending !== 8'h91) begin errors++; $display("FAIL burst_pend got=%h exp=91", pending); end
        Xin = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (valid !== 1'b1 || code_out !== 3'(exp_code[k])) begin
                errors++;
                $display("FAIL burst_code%0d got=v%b/%0d exp=v1/%0d", k, valid, code_out, exp_code[k]);
            end
        end
        tick();
        checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++; $display("FAIL burst_end got=v%b/%h exp=v0/00", valid, pending); end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        Xin = 8'h06;
        tick();
        checks++; if (pending !== 8'h06) begin errors++; $display("FAIL bp_pend got=%h exp=06", pending); end
        Xin = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (valid !== 1'b1 || code_out !== 3'd1 || pending !== 8'h04) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%b/%0d/%h exp=v1/1/04", k, valid, code_out, pending);
            end
        end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b1 || code_out !== 3'd2) begin
            errors++; $display("FAIL bp_next got=v%b/%0d exp=v1/2", valid, code_out); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%b exp=0", valid); end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        Xin = 8'h01;
        tick();
        Xin = 8'h00;
        tick();
        checks++; if (valid !== 1'b1 || code_out !== 3'd0) begin
            errors++; $display("FAIL ovf_hold got=v%b/%0d exp=v1/0", valid, code_out); end
        Xin = 8'h08;
        tick();
        Xin = 8'h00;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        Xin = 8'h08;
        tick();
        checks++; if (overflow !== 1'b1 || pending !== 8'h08) begin
            errors++; $display("FAIL ovf_set got=%b/%h exp=1/08", overflow, pending); end
        Xin = 8'h00;
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b1 || code_out !== 3'd3) begin
            errors++; $display("FAIL ovf_code got=v%b/%0d exp=v1/3", valid, code_out); end
        tick();
        checks++; if (valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_once got=v%b/o%b exp=v0/o1", valid, overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        Xin = 8'h04;
        tick();
        Xin = 8'h00;
        tick();
        Xin = 8'hF0;
        tick();
        Xin = 8'h00;
        checks++; if (valid !== 1'b1 || code_out !== 3'd2 || pending !== 8'hF0) begin
            errors++; $display("FAIL rmid_pre got=v%b/%0d/%h exp=v1/2/F0", valid, code_out, pending); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || code_out !== 3'd0 || pending !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got=v%b/%0d/%h/o%b exp=v0/0/00/o0", valid, code_out, pending, overflow);
        end
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
                errors++; $display("FAIL rmid_quiet%0d got=v%b/%h exp=v0/00", k, valid, pending); end
        end
    endtask

    task automatic test_roundtrip();
        logic [7:0] want;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            want = 8'd1 << i;
            Xin = want;
            tick();
            Xin = 8'h00;
            tick();
            checks++; if (decoded !== want) begin
                errors++; $display("FAIL roundtrip%0d got=%h exp=%h", i, decoded, want); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            checks++; if (valid !== m.valid) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, valid, m.valid); end
            checks++; if (pending !== m.pend) begin
                errors++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pending, m.pend); end
            checks++; if (overflow !== m.ovf) begin
                errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, overflow, m.ovf); end
            if (m.valid) begin
                checks++; if (code_out !== m.code[2:0]) begin
                    errors++; $display("FAIL rnd_code cyc=%0d got=%0d exp=%0d", c, code_out, m.code); end
            end
            if ($urandom_range(0, 2) == 0) Xin = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) Xin = 8'h00;
            ready   = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 11) == 0);
            tick();
        end
        Xin = 8'h00;
        ready = 1'b1;
        clr_ovf = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++; $display("FAIL rnd_drain got=v%b/%h exp=v0/00", valid, pending); end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_burst();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_roundtrip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
